updown_counter_gen: RTL and testbench
=====================================

# updown_counter_gen

Parametrised up/down counter for the counter subsystem. Adds programmable width, a runtime terminal limit, variable step, wrap or saturate mode, separate overflow/underflow pulses, a sticky error flag and an optional prescaler. It is a drop-in generalisation of the team's fixed 8-bit up/down counter for timers and event counters that need a modulus other than 2^W.

## Interface
- WIDTH, 8: counter, load, step and limit width (≥2)
- LIMIT_RST, {WIDTH{1'b1}}: limit register reset value
- PRESC_W, 4: prescaler width (used only with PRESCALE_EN)

- clk_in  input  1  clock; rising edge
- rst_in  input  1  reset, asynchronous, active-low
- en_ctrl_in  input  1  count enable
- set_ctrl_in  input  1  synchronous load of counter_in
- up_ctrl_in  input  1  1 = count up, 0 = count down
- sat_mode_in  input  1  1 = saturate at bounds, 0 = wrap modulo (limit+1)
- counter_in  input  WIDTH  load value
- step_in  input  WIDTH  increment/decrement amount; 0 treated as 1
- limit_in  input  WIDTH  new terminal value
- limit_wr_in  input  1  write limit_in into the limit register
- clr_sticky_in  input  1  clear ovf_sticky_out
- presc_in  input  PRESC_W  prescale divisor minus 1 (present only with PRESCALE_EN)
- counter_out  output  WIDTH  current count, registered
- ovf_out  output  1  one-cycle pulse: an up-step crossed the limit
- unf_out  output  1  one-cycle pulse: a down-step crossed 0
- tc_out  output  1  terminal count: (up and counter_out==limit) or (down and counter_out==0); combinational from registers and up_ctrl_in
- ovf_sticky_out  output  1  set by any ovf_out or unf_out pulse; cleared by clr_sticky_in

## Operation
- Valid range is 0..limit. The limit register resets to LIMIT_RST.
- Priority each edge, highest first: reset, set, clamp, count, hold.
- Set: counter ← min(counter_in, limit). No pulses. Overrides en_ctrl_in.
- Clamp: if counter > limit (after a limit write), counter ← limit on the next edge regardless of en_ctrl_in. No pulses.
- Count up, with s = effective step, computed in WIDTH+1 bits:
  - counter+s ≤ limit: counter ← counter+s.
  - Otherwise ovf_out=1, and then:
    - saturate: counter ← limit.
    - wrap: counter ← counter+s−(limit+1); if that result still exceeds limit (s > limit), counter ← 0.
- Count down:
  - counter ≥ s: counter ← counter−s.
  - Otherwise unf_out=1, and then:
    - saturate: counter ← 0.
    - wrap: counter ← counter+(limit+1)−s; if negative or > limit, counter ← limit.
- A saturated counter held at its bound with en_ctrl_in set pulses ovf_out/unf_out on every counting edge.
- Limit write: the limit register updates on the edge. The count update on that same edge uses the old limit.
- Sticky flag: a set event and clr_sticky_in on the same edge leave the flag at 1.
- With en_ctrl_in=0 and set_ctrl_in=0, the counter holds and the pulses are 0.

## Timing
- Reset (async assert, sync-free release) values: counter_out=0, ovf_out=0, unf_out=0, ovf_sticky_out=0, limit=LIMIT_RST, prescaler=0.
- Reset mid-count clears everything immediately, without waiting for a clock edge.
- Latency: all registered outputs update one edge after the qualifying inputs.
- ovf_out and unf_out are high for exactly the cycle after the crossing edge.
- ovf_sticky_out rises on the same edge as the pulse.
- tc_out follows up_ctrl_in combinationally. It has no extra latency relative to counter_out.

## Configuration
- PRESCALE_EN defined:
  - Adds the presc_in port and a PRESC_W-bit prescale counter.
  - A counting step occurs only on every (presc_in+1)-th edge with en_ctrl_in=1.
  - Disabled cycles freeze the prescale counter. A set operation or reset clears it.
- PRESCALE_EN undefined:
  - presc_in is absent.
  - Every enabled edge is a counting step.

## Test plan
- Async reset: WIDTH=8; count to 5, pull rst_in low between edges → counter_out=0, sticky=0, limit=255 immediately; first enabled up edge after release → 1.
- Wrap up: limit=9, count=9, step=1, up, wrap → counter_out=0, ovf_out high 1 cycle, sticky=1; clr_sticky_in → 0.
- Step wrap and underflow: limit=99, count=97, step=5, up → 2 with ovf; then down, step=5 → 97 with unf_out.
- Saturate: sat_mode=1, count=2, step=3, down → 0 with unf; held enabled for 2 more edges → stays 0, unf pulses each edge; tc_out=1.
- Set priority and clamp: limit=150, set_ctrl_in=1 and en_ctrl_in=1, counter_in=200 → 150, no pulse; then write limit=100 → counter=100 on the following edge.
- PRESCALE_EN: presc_in=3, en held, up → counter increments every 4th edge (0,0,0,1,1,1,1,2…).

Source files
------------

// File: rtl/updown_counter_gen.sv
// Parametrised up/down counter with runtime limit, variable step, wrap/saturate
// modes, overflow/underflow pulses and sticky error flag. Define PRESCALE_EN to add the step prescaler.
module updown_counter_gen #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] LIMIT_RST = {WIDTH{1'b1}},
  parameter int               PRESC_W   = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               en_ctrl_in,
  input  logic               set_ctrl_in,
  input  logic               up_ctrl_in,
  input  logic               sat_mode_in,
  input  logic [WIDTH-1:0]   counter_in,
  input  logic [WIDTH-1:0]   step_in,
  input  logic [WIDTH-1:0]   limit_in,
  input  logic               limit_wr_in,
  input  logic               clr_sticky_in,
`ifdef PRESCALE_EN
  input  logic [PRESC_W-1:0] presc_in,
`endif
  output logic [WIDTH-1:0]   counter_out,
  output logic               ovf_out,
  output logic               unf_out,
  output logic               tc_out,
  output logic               ovf_sticky_out
);

  logic [WIDTH-1:0] cnt_p0, cnt_p1;
  logic [WIDTH-1:0] lim_p1;
  logic [WIDTH-1:0] step_eff;
  logic [WIDTH:0]   up_res, dn_res;
  logic             ovf_p0, unf_p0;
  logic             ovf_p1, unf_p1, sticky_p1;
  logic             step_tick;

  // Returns {crossed, next}; arithmetic carried one bit wider so the sum cannot alias.
  function automatic logic [WIDTH:0] step_up(input logic [WIDTH-1:0] cnt,
                                             input logic [WIDTH-1:0] s,
                                             input logic [WIDTH-1:0] lim,
                                             input logic             sat);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] wrapv;
    sum   = {1'b0, cnt} + {1'b0, s};
    wrapv = sum - ({1'b0, lim} + (WIDTH+1)'(1));
    if (sum <= {1'b0, lim}) return {1'b0, sum[WIDTH-1:0]};
    if (sat)                return {1'b1, lim};
    if (wrapv > {1'b0, lim}) return {1'b1, {WIDTH{1'b0}}};
    return {1'b1, wrapv[WIDTH-1:0]};
  endfunction

  // Wrap result may go negative when the step exceeds the modulus; that pins to limit.
  function automatic logic [WIDTH:0] step_down(input logic [WIDTH-1:0] cnt,
                                               input logic [WIDTH-1:0] s,
                                               input logic [WIDTH-1:0] lim,
                                               input logic             sat);
    logic [WIDTH+1:0] t;
    t = {2'b00, cnt} + {2'b00, lim} + (WIDTH+2)'(1) - {2'b00, s};
    if (cnt >= s) return {1'b0, cnt - s};
    if (sat)      return {1'b1, {WIDTH{1'b0}}};
    if (t[WIDTH+1] || (t[WIDTH:0] > {1'b0, lim})) return {1'b1, lim};
    return {1'b1, t[WIDTH-1:0]};
  endfunction

`ifdef PRESCALE_EN
  logic [PRESC_W-1:0] presc_p1;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)          presc_p1 <= '0;
    else if (set_ctrl_in) presc_p1 <= '0;
    else if (en_ctrl_in)  presc_p1 <= (presc_p1 >= presc_in) ? '0 : presc_p1 + PRESC_W'(1);
  end

  // >= keeps the divider well-behaved if presc_in is lowered mid-period.
  assign step_tick = (presc_p1 >= presc_in);
`else
  assign step_tick = (PRESC_W > 0);
`endif

  assign step_eff = (step_in == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : step_in;
  assign up_res   = step_up(cnt_p1, step_eff, lim_p1, sat_mode_in);
  assign dn_res   = step_down(cnt_p1, step_eff, lim_p1, sat_mode_in);

  // Stage p0: next-count selection, priority set > clamp > count > hold
  always_comb begin
    cnt_p0 = cnt_p1;
    ovf_p0 = 1'b0;
    unf_p0 = 1'b0;
    if (set_ctrl_in) begin
      cnt_p0 = (counter_in > lim_p1) ? lim_p1 : counter_in;
    end else if (cnt_p1 > lim_p1) begin
      cnt_p0 = lim_p1;
    end else if (en_ctrl_in && step_tick) begin
      if (up_ctrl_in) begin
        cnt_p0 = up_res[WIDTH-1:0];
        ovf_p0 = up_res[WIDTH];
      end else begin
        cnt_p0 = dn_res[WIDTH-1:0];
        unf_p0 = dn_res[WIDTH];
      end
    end
  end

  // Stage p1: registered state; limit update lands after the count used the old value
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt_p1    <= '0;
      lim_p1    <= LIMIT_RST;
      ovf_p1    <= 1'b0;
      unf_p1    <= 1'b0;
      sticky_p1 <= 1'b0;
    end else begin
      cnt_p1    <= cnt_p0;
      ovf_p1    <= ovf_p0;
      unf_p1    <= unf_p0;
      sticky_p1 <= (sticky_p1 & ~clr_sticky_in) | ovf_p0 | unf_p0;
      if (limit_wr_in) lim_p1 <= limit_in;
    end
  end

  assign counter_out    = cnt_p1;
  assign ovf_out        = ovf_p1;
  assign unf_out        = unf_p1;
  assign ovf_sticky_out = sticky_p1;
  assign tc_out         = up_ctrl_in ? (cnt_p1 == lim_p1) : (cnt_p1 == '0);

endmodule

// File: tb/tb_updown_counter_gen.sv
// Self-checking bench for updown_counter_gen: directed scenarios followed by
// randomized traffic, all checked against an integer reference model.
module tb_updown_counter_gen;
  localparam int W = 8;

  logic         clk_in = 1'b0;
  logic         rst_in = 1'b0;
  logic         en_ctrl_in = 1'b0, set_ctrl_in = 1'b0, up_ctrl_in = 1'b1, sat_mode_in = 1'b0;
  logic [W-1:0] counter_in = '0, step_in = 8'd1, limit_in = '0;
  logic         limit_wr_in = 1'b0, clr_sticky_in = 1'b0;
`ifdef PRESCALE_EN
  logic [3:0]   presc_in = '0;
`endif
  logic [W-1:0] counter_out;
  logic         ovf_out, unf_out, tc_out, ovf_sticky_out;

  int n_cmp = 0;
  int n_fail = 0;
  int cnt_m, lim_m, ovf_m, unf_m, sticky_m, pc_m;

  updown_counter_gen #(.WIDTH(W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .en_ctrl_in(en_ctrl_in), .set_ctrl_in(set_ctrl_in),
    .up_ctrl_in(up_ctrl_in), .sat_mode_in(sat_mode_in), .counter_in(counter_in),
    .step_in(step_in), .limit_in(limit_in), .limit_wr_in(limit_wr_in),
    .clr_sticky_in(clr_sticky_in),
`ifdef PRESCALE_EN
    .presc_in(presc_in),
`endif
    .counter_out(counter_out), .ovf_out(ovf_out), .unf_out(unf_out),
    .tc_out(tc_out), .ovf_sticky_out(ovf_sticky_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cnt_m = 0; lim_m = (1 << W) - 1; ovf_m = 0; unf_m = 0; sticky_m = 0; pc_m = 0;
  endtask

  // Reference behaviour for one rising edge, computed from the counting rules.
  task automatic model_edge();
    int s, tick, presc;
    s = (step_in == 0) ? 1 : int'(step_in);
    presc = 0;
`ifdef PRESCALE_EN
    presc = int'(presc_in);
`endif
    tick = (pc_m >= presc);
    ovf_m = 0; unf_m = 0;
    if (set_ctrl_in) begin
      cnt_m = (int'(counter_in) < lim_m) ? int'(counter_in) : lim_m;
    end else if (cnt_m > lim_m) begin
      cnt_m = lim_m;
    end else if (en_ctrl_in && tick) begin
      if (up_ctrl_in) begin
        if (cnt_m + s <= lim_m) cnt_m = cnt_m + s;
        else begin
          ovf_m = 1;
          if (sat_mode_in) cnt_m = lim_m;
          else begin
            cnt_m = cnt_m + s - (lim_m + 1);
            if (cnt_m > lim_m) cnt_m = 0;
          end
        end
      end else begin
        if (cnt_m >= s) cnt_m = cnt_m - s;
        else begin
          unf_m = 1;
          if (sat_mode_in) cnt_m = 0;
          else begin
            cnt_m = cnt_m + (lim_m + 1) - s;
            if (cnt_m < 0 || cnt_m > lim_m) cnt_m = lim_m;
          end
        end
      end
    end
    if (set_ctrl_in) pc_m = 0;
    else if (en_ctrl_in) pc_m = tick ? 0 : pc_m + 1;
    if (ovf_m || unf_m) sticky_m = 1;
    else if (clr_sticky_in) sticky_m = 0;
    if (limit_wr_in) lim_m = int'(limit_in);
  endtask

  task automatic check_all(input string tag);
    int tc_m;
    tc_m = up_ctrl_in ? int'(cnt_m == lim_m) : int'(cnt_m == 0);
    chk({tag, ".cnt"}, 32'(counter_out), cnt_m);
    chk({tag, ".ovf"}, 32'(ovf_out), ovf_m);
    chk({tag, ".unf"}, 32'(unf_out), unf_m);
    chk({tag, ".sticky"}, 32'(ovf_sticky_out), sticky_m);
    chk({tag, ".tc"}, 32'(tc_out), tc_m);
  endtask

  task automatic tick(input string tag);
    @(posedge clk_in);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic en, input logic set, input logic up, input logic sat,
                       input int cin, input int stp, input int lim, input logic lwr,
                       input logic clr);
    en_ctrl_in = en; set_ctrl_in = set; up_ctrl_in = up; sat_mode_in = sat;
    counter_in = W'(cin); step_in = W'(stp); limit_in = W'(lim);
    limit_wr_in = lwr; clr_sticky_in = clr;
  endtask

  initial begin
    model_reset();
    #12;
    check_all("rst");
    rst_in = 1'b1;

    // async reset mid-count
    drive(1, 0, 1, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick("cnt5");
    chk("cnt_to_5", 32'(counter_out), 5);
    #3 rst_in = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    chk("async_rst_zero", 32'(counter_out), 0);
    #2 rst_in = 1'b1;
    tick("post_rst");
    chk("post_rst_first", 32'(counter_out), 1);

    // wrap up at limit 9
    drive(0, 0, 1, 0, 0, 1, 9, 1, 0); tick("lim9");
    drive(0, 1, 1, 0, 9, 1, 0, 0, 0); tick("set9");
    drive(1, 0, 1, 0, 0, 1, 0, 0, 0); tick("wrap9");
    chk("wrap9_cnt", 32'(counter_out), 0);
    chk("wrap9_ovf", 32'(ovf_out), 1);
    chk("wrap9_sticky", 32'(ovf_sticky_out), 1);
    drive(0, 0, 1, 0, 0, 1, 0, 0, 0); tick("ovf_drop");
    chk("ovf_one_cycle", 32'(ovf_out), 0);
    drive(0, 0, 1, 0, 0, 1, 0, 0, 1); tick("clr");
    chk("sticky_clr", 32'(ovf_sticky_out), 0);

    // step wrap and underflow at limit 99
    drive(0, 0, 1, 0, 0, 1, 99, 1, 0); tick("lim99");
    drive(0, 1, 1, 0, 97, 5, 0, 0, 0); tick("set97");
    drive(1, 0, 1, 0, 0, 5, 0, 0, 0); tick("up5");
    chk("up5_cnt", 32'(counter_out), 2);
    chk("up5_ovf", 32'(ovf_out), 1);
    drive(1, 0, 0, 0, 0, 5, 0, 0, 0); tick("dn5");
    chk("dn5_cnt", 32'(counter_out), 97);
    chk("dn5_unf", 32'(unf_out), 1);

    // saturate at zero
    drive(0, 1, 0, 1, 2, 3, 0, 0, 0); tick("set2");
    drive(1, 0, 0, 1, 0, 3, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick("sat_dn");
      chk("sat_dn_cnt", 32'(counter_out), 0);
      chk("sat_dn_unf", 32'(unf_out), 1);
    end
    chk("sat_tc", 32'(tc_out), 1);

    // set priority and clamp
    drive(0, 0, 1, 0, 0, 1, 150, 1, 0); tick("lim150");
    drive(1, 1, 1, 0, 200, 1, 0, 0, 0); tick("set200");
    chk("set_clip", 32'(counter_out), 150);
    chk("set_no_ovf", 32'(ovf_out), 0);
    drive(0, 0, 1, 0, 0, 1, 100, 1, 0); tick("lim100");
    chk("old_lim_hold", 32'(counter_out), 150);
    drive(0, 0, 1, 0, 0, 1, 0, 0, 0); tick("clamp");
    chk("clamp_cnt", 32'(counter_out), 100);
    chk("clamp_no_ovf", 32'(ovf_out), 0);

    // pulse and clear on the same edge keeps sticky high
    drive(1, 0, 1, 0, 0, 1, 0, 0, 1); tick("clr_vs_ovf");
    chk("clr_vs_ovf_sticky", 32'(ovf_sticky_out), 1);

    // zero step counts as one
    drive(0, 1, 1, 0, 10, 0, 0, 0, 0); tick("set10");
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0); tick("step0");
    chk("step0_cnt", 32'(counter_out), 11);

`ifdef PRESCALE_EN
    drive(0, 1, 1, 0, 0, 1, 0, 0, 0); tick("pre_set");
    presc_in = 4'd3;
    drive(1, 0, 1, 0, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      tick("presc");
      chk("presc_seq", 32'(counter_out), i / 4);
    end
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, ($urandom % 16) == 0, $urandom % 2, $urandom % 2,
            $urandom % 256, (($urandom % 16) == 0) ? $urandom % 256 : $urandom % 8,
            $urandom_range(2, 255), ($urandom % 20) == 0, ($urandom % 8) == 0);
`ifdef PRESCALE_EN
      presc_in = 4'($urandom % 3);
`endif
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
